laser_echo_responder: RTL and testbench
=======================================

// Module: laser_echo_responder
// PURPOSE
//  Target/reflector emulator: the responder end of the laser rangefinder link.
//  Watches the laser fire strobe L from the rangefinder controller.
//  Returns the echo strobe S after a programmed round-trip delay of 2*Dist cycles.
//  Used on-board and in benches as the "surface" so the rangefinder reads back D == Dist.
// PARAMETERS
//  WIDTH   16  width of Dist (distance in clock cycles, one way)
//  ECHO_W  1   S high time in cycles (>=1)
//  CNT_W   8   width of EchoCnt (saturating)
// PORTS
//  Clk      in   1        clock; all logic on posedge
//  Rst      in   1        reset, synchronous, active-high
//  L        in   1        laser fire strobe from controller (level; rising edge = shot)
//  En       in   1        target present; 0 = shot is absorbed, no echo
//  Dist     in   WIDTH    one-way distance in cycles, sampled on the shot edge
//  S        out  1        echo strobe to controller sensor input
//  Busy     out  1        1 while a shot is in flight or echoing (state != IDLE)
//  Drop     out  1        1-cycle pulse: shot ignored (En=0, or arrived while Busy)
//  EchoCnt  out  CNT_W    number of echoes issued, saturates at all-ones
// BEHAVIOUR
//  Reset (Rst=1 at an edge): S=0, Busy=0, Drop=0, EchoCnt=0, state=IDLE, counters=0.
//   Internal L_d is set to 1, so L held high through reset is NOT a shot.
//   L must be seen low before the first shot.
//  Shot = rising edge: L==1 && L_d==0 at an edge (edge k). L_d <= L every cycle.
//  Round trip N = max(1, 2*Dist), computed in WIDTH+1 bits; no overflow (max 2^(WIDTH+1)-2).
//  States:
//   IDLE:
//    - shot && En: Ctr <= N-1, latch N, go FLIGHT.
//    - shot && !En: Drop <= 1 for one cycle, stay IDLE.
//   FLIGHT:
//    - Ctr==0: S <= 1, Wctr <= ECHO_W-1, go ECHO.
//    - otherwise Ctr <= Ctr-1.
//   ECHO:
//    - Wctr==0: S <= 0, EchoCnt <= sat(EchoCnt+1), go IDLE.
//    - otherwise Wctr <= Wctr-1.
//  Timing: S registered, high from edge k+N through edge k+N+ECHO_W; latency exactly N cycles.
//  Shot while FLIGHT/ECHO: ignored (no retrigger, no queue), Drop pulses 1 cycle.
//   The current flight is unaffected.
//  Shot on the same edge that ECHO returns to IDLE: ignored with Drop.
//   The state seen at the edge governs.
//  Dist or En change mid-flight: no effect; both are sampled only at the shot edge.
//  Rst mid-flight/echo: abort; S=0 after that edge; no echo is issued later; EchoCnt cleared.
//  L held high for many cycles: one shot only; the next shot needs L low for >=1 cycle.
//  Busy = (state != IDLE), decoded from the state register (glitch-free).
//  End-to-end with the rangefinder controller (L high 1 cycle, counts until S seen):
//   the controller counts N+1 cycles, so floor((2*Dist+1)/2) = Dist.
//   The display D equals Dist for Dist>=1.
// STRUCTURE
//  Shared package (laser_pkg): state encodings IDLE/FLIGHT/ECHO (2-bit) and default WIDTH.
//   The rangefinder controller uses the same package.
//  One sub-module: laser_rise_det (registered L_d, reset-to-1, outputs shot). Reused for button B.
//  Top holds the FSM, the WIDTH+1 flight counter, the echo-width counter and the saturating EchoCnt.
// TESTING
//  1 Dist=5, En=1, L 0->1 for 1 cycle at edge k -> S high exactly at edge k+10 for 1 cycle;
//    Busy high k..k+10; EchoCnt=1.
//  2 Dist=0 -> S at k+1. Dist=16'hFFFF -> S at k+131070; no wrap.
//  3 En=0 at shot -> Drop 1 cycle at k, S stays 0, Busy 0.
//    En dropped mid-flight -> echo still at k+2*Dist.
//  4 Dist=20; second shot at k+7; Dist changed to 3 at k+1 -> Drop at k+7, single S at k+40.
//  5 Rst asserted at k+4 of Dist=10 flight -> S never rises, Busy=0, EchoCnt=0.
//    L held high through reset -> no shot.
//  6 Closed loop with the rangefinder controller, Dist in {1,7,100}, ECHO_W=1 and 3
//    -> controller D = 1, 7, 100; 300 shots with CNT_W=8 -> EchoCnt saturates at 255.

Source files
------------

// File: rtl/laser_pkg.sv
// laser_pkg: state encodings and defaults shared by the rangefinder controller and echo responder
package laser_pkg;
  typedef enum logic [1:0] {IDLE, FLIGHT, ECHO} state_t;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/laser_rise_det.sv
// laser_rise_det: registered rising-edge detector; the delayed copy resets high so a held input is not an edge
module laser_rise_det (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic shot
);
  logic d_q;
  always_ff @(posedge Clk) begin
    if (Rst) d_q <= 1'b1;
    else d_q <= d;
  end
  assign shot = d & ~d_q;
endmodule

// File: rtl/laser_echo_responder.sv
// laser_echo_responder: returns an echo strobe S a programmed 2*Dist cycles after each laser shot
module laser_echo_responder import laser_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ECHO_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             L,
  input  logic             En,
  input  logic [WIDTH-1:0] Dist,
  output logic             S,
  output logic             Busy,
  output logic             Drop,
  output logic [CNT_W-1:0] EchoCnt
);
  localparam int EW = ECHO_W > 1 ? $clog2(ECHO_W) : 1;
  state_t state, state_n;
  logic [WIDTH:0] ctr, ctr_n, n_rt;
  logic [EW-1:0] wctr, wctr_n;
  logic [CNT_W-1:0] cnt_n;
  logic s_n, drop_n, shot;
  laser_rise_det u_rise (.Clk(Clk), .Rst(Rst), .d(L), .shot(shot));
  // one extra bit so 2*Dist never wraps; zero distance still needs one cycle
  assign n_rt = Dist == '0 ? (WIDTH+1)'(1) : {Dist, 1'b0};
  always_comb begin
    state_n = state;
    ctr_n = ctr;
    wctr_n = wctr;
    s_n = S;
    drop_n = 1'b0;
    cnt_n = EchoCnt;
    case (state)
      IDLE: begin
        if (shot && En) begin
          ctr_n = n_rt - (WIDTH+1)'(1);
          state_n = FLIGHT;
        end
        drop_n = shot && !En;
      end
      FLIGHT: begin
        drop_n = shot;
        if (ctr == '0) begin
          s_n = 1'b1;
          wctr_n = EW'(ECHO_W - 1);
          state_n = ECHO;
        end else ctr_n = ctr - (WIDTH+1)'(1);
      end
      ECHO: begin
        drop_n = shot;
        if (wctr == '0) begin
          s_n = 1'b0;
          cnt_n = &EchoCnt ? EchoCnt : EchoCnt + CNT_W'(1);
          state_n = IDLE;
        end else wctr_n = wctr - EW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ctr <= '0;
      wctr <= '0;
      S <= 1'b0;
      Drop <= 1'b0;
      EchoCnt <= '0;
    end else begin
      state <= state_n;
      ctr <= ctr_n;
      wctr <= wctr_n;
      S <= s_n;
      Drop <= drop_n;
      EchoCnt <= cnt_n;
    end
  end
  assign Busy = state != IDLE;
endmodule

// File: tb/tb_laser_echo_responder.sv
// tb_laser_echo_responder: directed checks of echo latency, drops, reset abort and counter saturation
module tb_laser_echo_responder;
  logic Clk = 1'b0, Rst = 1'b1, L = 1'b0, En = 1'b1;
  logic [15:0] Dist = '0;
  logic S, Busy, Drop, S3, Busy3, Drop3;
  logic [7:0] EchoCnt, EchoCnt3;
  int total = 0, bad = 0, cyc = 0;

  laser_echo_responder #(.WIDTH(16), .ECHO_W(1), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .L(L), .En(En), .Dist(Dist),
    .S(S), .Busy(Busy), .Drop(Drop), .EchoCnt(EchoCnt));
  laser_echo_responder #(.WIDTH(16), .ECHO_W(3), .CNT_W(8)) dut3 (
    .Clk(Clk), .Rst(Rst), .L(L), .En(En), .Dist(Dist),
    .S(S3), .Busy(Busy3), .Drop(Drop3), .EchoCnt(EchoCnt3));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic fire(output int k);
    L = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    L = 1'b0;
    k = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_s(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge Clk);
      if (S === 1'b1) at = cyc;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; L = 1'b1;
    idle(3);
    total++; if (S !== 1'b0) begin bad++; $display("FAIL reset_s got=%0b want=0", S); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", Busy); end
    total++; if (Drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0b want=0", Drop); end
    total++; if (EchoCnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", EchoCnt); end
    Rst = 1'b0;
    idle(3);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL held_l_busy got=%0b want=0", Busy); end
    total++; if (Drop !== 1'b0) begin bad++; $display("FAIL held_l_drop got=%0b want=0", Drop); end
    L = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int k, first, first3, hits, hits3;
    logic busy_k, busy_10, busy3_12;
    Dist = 16'd5; En = 1'b1;
    fire(k);
    busy_k = Busy;
    first = -1; first3 = -1; hits = 0; hits3 = 0; busy_10 = 1'b0; busy3_12 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (S === 1'b1) begin hits++; if (first < 0) first = cyc - k; end
      if (S3 === 1'b1) begin hits3++; if (first3 < 0) first3 = cyc - k; end
      if (cyc - k == 10) busy_10 = Busy;
      if (cyc - k == 12) busy3_12 = Busy3;
    end
    total++; if (busy_k !== 1'b1) begin bad++; $display("FAIL basic_busy_k got=%0b want=1", busy_k); end
    total++; if (busy_10 !== 1'b1) begin bad++; $display("FAIL basic_busy_k10 got=%0b want=1", busy_10); end
    total++; if (first != 10) begin bad++; $display("FAIL basic_latency got=%0d want=10", first); end
    total++; if (hits != 1) begin bad++; $display("FAIL basic_width got=%0d want=1", hits); end
    total++; if (first3 != 10) begin bad++; $display("FAIL w3_latency got=%0d want=10", first3); end
    total++; if (hits3 != 3) begin bad++; $display("FAIL w3_width got=%0d want=3", hits3); end
    total++; if (busy3_12 !== 1'b1) begin bad++; $display("FAIL w3_busy_k12 got=%0b want=1", busy3_12); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", Busy); end
    total++; if (EchoCnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d want=1", EchoCnt); end
    total++; if (EchoCnt3 !== 8'd1) begin bad++; $display("FAIL w3_cnt got=%0d want=1", EchoCnt3); end
  endtask

  task automatic test_dist_edges;
    int k, at;
    Dist = 16'd0;
    fire(k);
    wait_s(10, at);
    total++; if (at - k != 1) begin bad++; $display("FAIL dist0_latency got=%0d want=1", at - k); end
    idle(5);
    Dist = 16'h8000;
    fire(k);
    wait_s(70000, at);
    total++; if (at - k != 65536) begin bad++; $display("FAIL dist8000_latency got=%0d want=65536", at - k); end
    idle(5);
    total++; if (EchoCnt !== 8'd3) begin bad++; $display("FAIL dist_cnt got=%0d want=3", EchoCnt); end
  endtask

  task automatic test_absorb;
    int k, at, hits;
    En = 1'b0; Dist = 16'd3;
    fire(k);
    total++; if (Drop !== 1'b1) begin bad++; $display("FAIL absorb_drop got=%0b want=1", Drop); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL absorb_busy got=%0b want=0", Busy); end
    idle(1);
    total++; if (Drop !== 1'b0) begin bad++; $display("FAIL absorb_drop_len got=%0b want=0", Drop); end
    hits = 0;
    for (int i = 0; i < 10; i++) begin @(negedge Clk); if (S === 1'b1) hits++; end
    total++; if (hits != 0) begin bad++; $display("FAIL absorb_s got=%0d want=0", hits); end
    En = 1'b1; Dist = 16'd4;
    fire(k);
    En = 1'b0;
    wait_s(20, at);
    total++; if (at - k != 8) begin bad++; $display("FAIL en_mid_latency got=%0d want=8", at - k); end
    En = 1'b1;
    idle(3);
  endtask

  task automatic test_back_to_back;
    int k, first, hits;
    logic drop7, drop_ret, busy_ret;
    Dist = 16'd20;
    fire(k);
    first = -1; hits = 0; drop7 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (cyc - k == 1) Dist = 16'd3;
      if (cyc - k == 6) L = 1'b1;
      if (cyc - k == 7) begin drop7 = Drop; L = 1'b0; end
      if (S === 1'b1) begin hits++; if (first < 0) first = cyc - k; end
    end
    total++; if (drop7 !== 1'b1) begin bad++; $display("FAIL b2b_drop got=%0b want=1", drop7); end
    total++; if (first != 40) begin bad++; $display("FAIL b2b_latency got=%0d want=40", first); end
    total++; if (hits != 1) begin bad++; $display("FAIL b2b_hits got=%0d want=1", hits); end
    Dist = 16'd2;
    fire(k);
    drop_ret = 1'b0; busy_ret = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (cyc - k == 4) L = 1'b1;
      if (cyc - k == 5) begin drop_ret = Drop; busy_ret = Busy; L = 1'b0; end
    end
    total++; if (drop_ret !== 1'b1) begin bad++; $display("FAIL ret_edge_drop got=%0b want=1", drop_ret); end
    total++; if (busy_ret !== 1'b0) begin bad++; $display("FAIL ret_edge_busy got=%0b want=0", busy_ret); end
    total++; if (EchoCnt !== 8'd6) begin bad++; $display("FAIL b2b_cnt got=%0d want=6", EchoCnt); end
  endtask

  task automatic test_reset_mid;
    int k, hits;
    Dist = 16'd10;
    fire(k);
    idle(3);
    Rst = 1'b1;
    idle(1);
    Rst = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", Busy); end
    total++; if (EchoCnt !== 8'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d want=0", EchoCnt); end
    hits = 0;
    for (int i = 0; i < 30; i++) begin @(negedge Clk); if (S === 1'b1 || S3 === 1'b1) hits++; end
    total++; if (hits != 0) begin bad++; $display("FAIL rst_mid_s got=%0d want=0", hits); end
  endtask

  task automatic test_closed_loop;
    int k, at, at3, d;
    int dists[3] = '{1, 7, 100};
    foreach (dists[j]) begin
      Dist = 16'(dists[j]);
      fire(k);
      at = -1; at3 = -1;
      for (int i = 0; i < 300 && (at < 0 || at3 < 0); i++) begin
        @(negedge Clk);
        if (S === 1'b1 && at < 0) at = cyc;
        if (S3 === 1'b1 && at3 < 0) at3 = cyc;
      end
      d = (at - k + 1) / 2;
      total++; if (at < 0 || d != dists[j]) begin bad++; $display("FAIL loop_d got=%0d want=%0d", d, dists[j]); end
      d = (at3 - k + 1) / 2;
      total++; if (at3 < 0 || d != dists[j]) begin bad++; $display("FAIL loop_d_w3 got=%0d want=%0d", d, dists[j]); end
      idle(6);
    end
    total++; if (EchoCnt !== 8'd3) begin bad++; $display("FAIL loop_cnt got=%0d want=3", EchoCnt); end
    Dist = 16'd0;
    for (int i = 0; i < 300; i++) begin fire(k); idle(3); end
    total++; if (EchoCnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", EchoCnt); end
  endtask

  initial begin
    idle(1);
    test_reset;
    test_basic;
    test_dist_edges;
    test_absorb;
    test_back_to_back;
    test_reset_mid;
    test_closed_loop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
